mem_dbus_stage: RTL and testbench

- MEM pipeline stage. Consumes the EX/MEM register outputs and performs load/store through a registered request/acknowledge data bus.
- Generates byte lanes and load extension, and detects address errors.
- Holds the pipeline with stallreq until the bus acknowledges. Feeds the MEM/WB register.

---
 rtl/mem_dbus_stage_pkg.sv | 51 +++++
 rtl/mem_dbus_stage_lane_fmt.sv | 55 +++++
 rtl/mem_dbus_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_dbus_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dbus_stage_pkg.sv
// Shared widths, ALU op codes, exception bit positions and access helpers for the MEM data-bus stage.
package mem_dbus_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    localparam int EXC_ADEL_BIT   = 13;
    localparam int EXC_ADES_BIT   = 14;
    localparam int EXC_BUSERR_BIT = 15;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic acc_size_e acc_size(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
            EXE_LW_OP, EXE_SW_OP:             return SZ_WORD;
            default:                          return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_dbus_stage_lane_fmt.sv
// Big-endian byte-lane formatting: byte enables, store replication, load extraction and extension.
module mem_lane_fmt
    import mem_dbus_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [REG_W-1:0]   reg2_i,
    input  logic [REG_W-1:0]   rdata_i,
    output logic [3:0]         sel_o,
    output logic [REG_W-1:0]   wdata_o,
    output logic [REG_W-1:0]   ldata_o
);

    logic       sign_ext;
    logic [7:0] byte_v;
    logic [15:0] half_v;

    assign sign_ext = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LH_OP);

    // Lane 0 of the address is the most significant byte of the word.
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_v = rdata_i[31:24];
            2'b01:   byte_v = rdata_i[23:16];
            2'b10:   byte_v = rdata_i[15:8];
            default: byte_v = rdata_i[7:0];
        endcase
        half_v = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    always_comb begin
        sel_o   = 4'b0000;
        wdata_o = ZERO_WORD;
        ldata_o = ZERO_WORD;
        case (acc_size(aluop_i))
            SZ_BYTE: begin
                sel_o   = 4'b1000 >> addr_lo_i;
                wdata_o = {4{reg2_i[7:0]}};
                ldata_o = {{24{sign_ext & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{reg2_i[15:0]}};
                ldata_o = {{16{sign_ext & half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                sel_o   = 4'b1111;
                wdata_o = reg2_i;
                ldata_o = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_dbus_stage.sv
// MEM stage with registered req/ack data bus, address checks and pipeline hold.
// Optional bus timeout enabled by defining DBUS_TIMEOUT_EN.
module mem_dbus_stage
    import mem_dbus_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [5:0]            stall,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [REG_W-1:0]      mem_wdata,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [REG_W-1:0]      mem_mem_addr,
    input  logic [REG_W-1:0]      mem_reg2,
    input  logic [31:0]           mem_excepttype,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [31:0]           dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [31:0]           dbus_wdata,
    input  logic [31:0]           dbus_rdata,
    input  logic                  dbus_ack,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [REG_W-1:0]      wb_wdata,
    output logic [31:0]           excepttype_o,
    output logic [31:0]           badvaddr_o,
    output logic                  stallreq
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic [3:0]  sel_q, sel_d;
    logic        buserr_q, buserr_d;
    logic        tmo;

    logic        ld, st, is_mem, misalign, exc_in, access_ok;
    acc_size_e   size;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata, lane_ldata;

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    assign ld        = is_load(mem_aluop);
    assign st        = is_store(mem_aluop);
    assign is_mem    = ld | st;
    assign size      = acc_size(mem_aluop);
    assign misalign  = ((size == SZ_HALF) && mem_mem_addr[0]) ||
                       ((size == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00));
    assign exc_in    = |mem_excepttype;
    assign access_ok = is_mem && !misalign && !exc_in;

    mem_lane_fmt u_lane_fmt (
        .aluop_i   (mem_aluop),
        .addr_lo_i (mem_mem_addr[1:0]),
        .reg2_i    (mem_reg2),
        .rdata_i   (rbuf_q),
        .sel_o     (lane_sel),
        .wdata_o   (lane_wdata),
        .ldata_o   (lane_ldata)
    );

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires on the cycle that would otherwise be the TIMEOUT_CYCLES-th unacknowledged one.
    assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !dbus_ack;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) && ((state_d == ST_BUSY) || (state_d == ST_ABORT)))
            cnt_d = '0;
        else if ((state_q == ST_BUSY) || (state_q == ST_ABORT))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        buserr_d = buserr_q;
        case (state_q)
            ST_IDLE: begin
                if (access_ok && !flush) begin
                    state_d  = ST_BUSY;
                    req_d    = 1'b1;
                    we_d     = st;
                    addr_d   = {mem_mem_addr[31:2], 2'b00};
                    sel_d    = lane_sel;
                    wdata_d  = st ? lane_wdata : ZERO_WORD;
                    buserr_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    state_d = flush ? ST_IDLE : ST_DONE;
                    if (!flush) rbuf_d = dbus_rdata;
                end else if (flush) begin
                    state_d = ST_ABORT;
                end else if (tmo) begin
                    req_d    = 1'b0;
                    buserr_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_ABORT: begin
                // The bus cycle must complete even though its result is unwanted.
                if (dbus_ack || tmo) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (flush || (stall[4] == NO_STOP)) begin
                    state_d  = ST_IDLE;
                    buserr_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            buserr_q <= buserr_d;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;

    assign stallreq = ((state_q == ST_IDLE) && access_ok && !flush) || (state_q == ST_BUSY);

    always_comb begin
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        excepttype_o = mem_excepttype;
        badvaddr_o   = ZERO_WORD;
        if (exc_in) begin
            wb_wreg = 1'b0;
        end else if (is_mem && misalign) begin
            wb_wreg    = 1'b0;
            badvaddr_o = mem_mem_addr;
            if (ld) excepttype_o[EXC_ADEL_BIT] = 1'b1;
            else    excepttype_o[EXC_ADES_BIT] = 1'b1;
        end else if (is_mem) begin
            wb_wreg = 1'b0;
            if ((state_q == ST_DONE) && buserr_q) begin
                excepttype_o[EXC_BUSERR_BIT] = 1'b1;
                badvaddr_o                   = mem_mem_addr;
            end else if ((state_q == ST_DONE) && ld) begin
                wb_wreg  = mem_wreg;
                wb_wdata = lane_ldata;
            end
        end
    end

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Directed self-checking bench for mem_dbus_stage; the timeout scenario is built only with DBUS_TIMEOUT_EN.
module tb_mem_dbus_stage;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
`ifdef DBUS_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk, rst, flush;
    logic [5:0]  stall;
    logic [4:0]  mem_wd, wb_wd;
    logic        mem_wreg, wb_wreg;
    logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, mem_excepttype;
    logic [7:0]  mem_aluop;
    logic        dbus_req, dbus_we, dbus_ack, stallreq;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, wb_wdata, excepttype_o, badvaddr_o;
    logic [3:0]  dbus_sel;

    int checks = 0;
    int errors = 0;

    mem_dbus_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_excepttype(mem_excepttype),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
        .dbus_ack(dbus_ack),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .excepttype_o(excepttype_o), .badvaddr_o(badvaddr_o), .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] wd, input logic wreg);
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wd       = wd;
        mem_wreg     = wreg;
        mem_wdata    = addr;
        #1;
    endtask

    task automatic set_nop();
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; stall = 6'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        mem_excepttype = 32'h0;
        set_nop();
        #12;
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", dbus_req); end
        checks++; if (dbus_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", dbus_we); end
        checks++; if (dbus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", dbus_addr); end
        checks++; if (dbus_sel !== 4'h0) begin errors++; $display("FAIL reset_sel got %b exp 0000", dbus_sel); end
        checks++; if (dbus_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", dbus_wdata); end
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %b exp 0", stallreq); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        set_op(OP_ADD, 32'h0000_1234, 32'h0, 5'd9, 1'b1);
        checks++; if (wb_wdata !== 32'h0000_1234) begin errors++; $display("FAIL pass_wdata got %h exp 00001234", wb_wdata); end
        checks++; if ({wb_wd, wb_wreg} !== {5'd9, 1'b1}) begin errors++; $display("FAIL pass_wd_wreg got %h/%b exp 09/1", wb_wd, wb_wreg); end
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL pass_stallreq got %b exp 0", stallreq); end
        tick();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL pass_req got %b exp 0", dbus_req); end
        set_nop();
    endtask

    task automatic test_lb();
        int stalls = 0;
        set_op(OP_LB, 32'h0000_0103, 32'h0, 5'd3, 1'b1);
        dbus_rdata = 32'h1122_3380;
        if (stallreq) stalls++;
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL lb_req_early got %b exp 0", dbus_req); end
        tick();
        dbus_ack = 1'b1; #1;
        if (stallreq) stalls++;
        checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL lb_req got %b exp 1", dbus_req); end
        checks++; if (dbus_sel !== 4'b0001) begin errors++; $display("FAIL lb_sel got %b exp 0001", dbus_sel); end
        checks++; if (dbus_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", dbus_addr); end
        checks++; if (dbus_we !== 1'b0) begin errors++; $display("FAIL lb_we got %b exp 0", dbus_we); end
        tick();
        dbus_ack = 1'b0; #1;
        if (stallreq) stalls++;
        checks++; if (wb_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_wdata got %h exp ffffff80", wb_wdata); end
        checks++; if (wb_wreg !== 1'b1) begin errors++; $display("FAIL lb_wb_wreg got %b exp 1", wb_wreg); end
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL lb_req_done got %b exp 0", dbus_req); end
        checks++; if (stalls != 2) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 2", stalls); end
        tick();
        set_nop();
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lb_idle_stallreq got %b exp 0", stallreq); end
    endtask

    task automatic test_sh();
        set_op(OP_SH, 32'h0000_0202, 32'h0000_BEEF, 5'd4, 1'b1);
        tick();
        dbus_ack = 1'b1; #1;
        checks++; if (dbus_we !== 1'b1) begin errors++; $display("FAIL sh_we got %b exp 1", dbus_we); end
        checks++; if (dbus_sel !== 4'b0011) begin errors++; $display("FAIL sh_sel got %b exp 0011", dbus_sel); end
        checks++; if (dbus_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", dbus_wdata); end
        checks++; if (dbus_addr !== 32'h0000_0200) begin errors++; $display("FAIL sh_addr got %h exp 00000200", dbus_addr); end
        tick();
        dbus_ack = 1'b0; #1;
        checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL sh_wb_wreg got %b exp 0", wb_wreg); end
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL sh_done_stallreq got %b exp 0", stallreq); end
        tick();
        set_nop();
    endtask

    task automatic test_misalign();
        set_op(OP_LW, 32'h0000_0101, 32'h0, 5'd5, 1'b1);
        checks++; if (excepttype_o !== 32'h0000_2000) begin errors++; $display("FAIL adel_exc got %h exp 00002000", excepttype_o); end
        checks++; if (badvaddr_o !== 32'h0000_0101) begin errors++; $display("FAIL adel_badvaddr got %h exp 00000101", badvaddr_o); end
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL adel_stallreq got %b exp 0", stallreq); end
        checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL adel_wb_wreg got %b exp 0", wb_wreg); end
        tick();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL adel_req got %b exp 0", dbus_req); end
        set_op(OP_SW, 32'h0000_0102, 32'h1, 5'd0, 1'b0);
        checks++; if (excepttype_o !== 32'h0000_4000) begin errors++; $display("FAIL ades_exc got %h exp 00004000", excepttype_o); end
        tick();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL ades_req got %b exp 0", dbus_req); end
        set_op(OP_LW, 32'h0000_0100, 32'h0, 5'd5, 1'b1);
        mem_excepttype = 32'h0000_0100; #1;
        checks++; if ({stallreq, wb_wreg} !== 2'b00) begin errors++; $display("FAIL excin_block got %b exp 00", {stallreq, wb_wreg}); end
        checks++; if (excepttype_o !== 32'h0000_0100) begin errors++; $display("FAIL excin_merge got %h exp 00000100", excepttype_o); end
        tick();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL excin_req got %b exp 0", dbus_req); end
        mem_excepttype = 32'h0;
        set_nop();
    endtask

    task automatic test_lhu_delayed();
        int stalls = 0;
        int reqs = 0;
        logic prev = 1'b0;
        set_op(OP_LHU, 32'h0000_0300, 32'h0, 5'd7, 1'b1);
        dbus_rdata = 32'hABCD_1234;
        if (stallreq) stalls++;
        tick();
        for (int i = 1; i <= 5; i++) begin
            dbus_ack = (i == 5); #1;
            if (stallreq) stalls++;
            if (dbus_req && !prev) reqs++;
            prev = dbus_req;
            tick();
        end
        dbus_ack = 1'b0;
        stall = 6'b011111; #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (wb_wdata !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu_hold_wdata%0d got %h exp 0000abcd", i, wb_wdata); end
            checks++; if ({dbus_req, stallreq} !== 2'b00) begin errors++; $display("FAIL lhu_hold_req%0d got %b exp 00", i, {dbus_req, stallreq}); end
            tick();
        end
        stall = 6'b0; #1;
        checks++; if (wb_wreg !== 1'b1) begin errors++; $display("FAIL lhu_wb_wreg got %b exp 1", wb_wreg); end
        checks++; if (stalls != 6) begin errors++; $display("FAIL lhu_stall_cycles got %0d exp 6", stalls); end
        checks++; if (reqs != 1) begin errors++; $display("FAIL lhu_req_count got %0d exp 1", reqs); end
        tick();
        set_nop();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL lhu_idle_req got %b exp 0", dbus_req); end
    endtask

    task automatic test_flush_abort();
        set_op(OP_LW, 32'h0000_0400, 32'h0, 5'd8, 1'b1);
        tick();
        flush = 1'b1; #1;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL abort_busy_stallreq got %b exp 1", stallreq); end
        tick();
        flush = 1'b0;
        set_nop();
        for (int i = 0; i < 2; i++) begin
            checks++; if ({dbus_req, stallreq} !== 2'b10) begin errors++; $display("FAIL abort_hold%0d got %b exp 10", i, {dbus_req, stallreq}); end
            tick();
        end
        dbus_ack = 1'b1; dbus_rdata = 32'h5555_5555; #1;
        checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL abort_req_at_ack got %b exp 1", dbus_req); end
        tick();
        dbus_ack = 1'b0; #1;
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL abort_req_after got %b exp 0", dbus_req); end
        // A fresh load proves the stage is back in IDLE (immediate stall request).
        set_op(OP_LW, 32'h0000_0500, 32'h0, 5'd8, 1'b1);
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL abort_idle got %b exp 1", stallreq); end
        tick();
        rst = 1'b0; #1;
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", dbus_req); end
        set_nop();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ack_flush_same();
        set_op(OP_LW, 32'h0000_0600, 32'h0, 5'd2, 1'b1);
        tick();
        flush = 1'b1; dbus_ack = 1'b1; #1;
        tick();
        flush = 1'b0; dbus_ack = 1'b0;
        set_nop();
        checks++; if ({dbus_req, stallreq} !== 2'b00) begin errors++; $display("FAIL ackflush_idle got %b exp 00", {dbus_req, stallreq}); end
        tick();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL ackflush_noreissue got %b exp 0", dbus_req); end
    endtask

`ifdef DBUS_TIMEOUT_EN
    task automatic test_timeout();
        int reqs = 0;
        set_op(OP_LW, 32'h0000_0700, 32'h0, 5'd6, 1'b1);
        tick();
        for (int i = 0; i < 10 && dbus_req; i++) begin
            reqs++;
            tick();
        end
        checks++; if (reqs != 4) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 4", reqs); end
        checks++; if (excepttype_o[15] !== 1'b1) begin errors++; $display("FAIL tmo_buserr got %b exp 1", excepttype_o[15]); end
        checks++; if ({wb_wreg, stallreq} !== 2'b00) begin errors++; $display("FAIL tmo_wreg_stall got %b exp 00", {wb_wreg, stallreq}); end
        checks++; if (badvaddr_o !== 32'h0000_0700) begin errors++; $display("FAIL tmo_badvaddr got %h exp 00000700", badvaddr_o); end
        tick();
        set_nop();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_misalign();
        test_lhu_delayed();
        test_flush_abort();
        test_ack_flush_same();
`ifdef DBUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
